// File: rtl/bp_be_clear_queue.sv
// rtl/bp_be_clear_queue.sv - in-order queue of writeback completions draining one scoreboard clear per cycle
// Options: BP_BE_CLEAR_QUEUE_BYPASS_EN (same-cycle clear when empty), BP_BE_CLEAR_QUEUE_OVERFLOW_FATAL (overflow assertion)
module bp_be_clear_queue #(
    parameter int num_wb_p          = 2,
    parameter int els_p             = 4,
    parameter int reg_addr_width_gp = 5,
    localparam int cnt_w_lp         = $clog2(els_p + 1),
    localparam int ptr_w_lp         = $clog2(els_p)
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,
    input  logic [num_wb_p-1:0]                   wb_v_i,
    input  logic [num_wb_p*reg_addr_width_gp-1:0] wb_rd_i,
    output logic                                  ready_o,
    output logic                                  clear_v_o,
    output logic [reg_addr_width_gp-1:0]          clear_rd_o,
    output logic [cnt_w_lp-1:0]                   count_o,
    output logic                                  overflow_o
);
    typedef logic [reg_addr_width_gp-1:0] rd_t;

    rd_t [els_p-1:0]     mem_q, mem_d;
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d, n_enq;
    logic                overflow_q, overflow_d;
    logic [num_wb_p-1:0] keep, enq_mask;
    logic                deq, byp_v;
    rd_t                 byp_rd;

    // Writes to x0 never need a scoreboard clear.
    always_comb begin
        keep = '0;
        for (int i = 0; i < num_wb_p; i++) begin
            keep[i] = wb_v_i[i] && (wb_rd_i[i*reg_addr_width_gp +: reg_addr_width_gp] != '0);
        end
    end

`ifdef BP_BE_CLEAR_QUEUE_BYPASS_EN
    // Lowest-index survivor skips the empty queue; keep & (keep-1) drops exactly that source.
    always_comb begin
        byp_v    = (count_q == '0) && (|keep);
        byp_rd   = '0;
        for (int i = num_wb_p - 1; i >= 0; i--) begin
            if (keep[i]) byp_rd = rd_t'(wb_rd_i[i*reg_addr_width_gp +: reg_addr_width_gp]);
        end
        enq_mask = byp_v ? (keep & (keep - num_wb_p'(1))) : keep;
    end
`else
    assign byp_v    = 1'b0;
    assign byp_rd   = '0;
    assign enq_mask = keep;
`endif

    assign ready_o = (count_q <= cnt_w_lp'(els_p - num_wb_p));
    assign deq     = (count_q != '0);

    always_comb begin
        mem_d = mem_q;
        n_enq = '0;
        for (int i = 0; i < num_wb_p; i++) begin
            if (ready_o && enq_mask[i]) begin
                mem_d[wr_ptr_q + ptr_w_lp'(n_enq)] =
                    rd_t'(wb_rd_i[i*reg_addr_width_gp +: reg_addr_width_gp]);
                n_enq = n_enq + cnt_w_lp'(1);
            end
        end
        count_d    = count_q + n_enq - cnt_w_lp'(deq);
        rd_ptr_d   = rd_ptr_q + ptr_w_lp'(deq);
        wr_ptr_d   = wr_ptr_q + ptr_w_lp'(n_enq);
        overflow_d = overflow_q | (!ready_o && (|keep));
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mem_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign clear_v_o  = deq | byp_v;
    assign clear_rd_o = deq ? mem_q[rd_ptr_q] : byp_rd;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;

`ifdef BP_BE_CLEAR_QUEUE_OVERFLOW_FATAL
    overflow_a: assert property (@(posedge clk_i) disable iff (!reset_n_i) !( !ready_o && (|keep)))
        else $fatal(1, "bp_be_clear_queue: completion dropped while not ready");
`endif
endmodule

// File: tb/tb_bp_be_clear_queue.sv
// tb/tb_bp_be_clear_queue.sv - vector table, corner sequences and random run against a queue model
module tb_bp_be_clear_queue;
    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic [1:0] wb_v_i;
    logic [9:0] wb_rd_i;
    logic       ready_o, clear_v_o, overflow_o;
    logic [4:0] clear_rd_o;
    logic [2:0] count_o;

    bp_be_clear_queue #(.num_wb_p(2), .els_p(4), .reg_addr_width_gp(5)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .wb_v_i(wb_v_i), .wb_rd_i(wb_rd_i),
        .ready_o(ready_o), .clear_v_o(clear_v_o), .clear_rd_o(clear_rd_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] v;
        int r0, r1;
        int rdy, cv, rd, cnt, ovf;
    } vec_t;

    vec_t tbl[16];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mq[$];
    int   movf;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_chk(input string name, input logic [1:0] v, input int r0, input int r1,
                             input int erdy, input int ecv, input int erd, input int ecnt,
                             input int eovf);
        @(negedge clk_i);
        wb_v_i  = v;
        wb_rd_i = {5'(r1), 5'(r0)};
        #2;
        chk({name, ".ready"},    int'(ready_o),    erdy);
        chk({name, ".clear_v"},  int'(clear_v_o),  ecv);
        chk({name, ".clear_rd"}, int'(clear_rd_o), erd);
        chk({name, ".count"},    int'(count_o),    ecnt);
        chk({name, ".overflow"}, int'(overflow_o), eovf);
    endtask

    // Reference: a plain FIFO of register numbers; head pops each cycle, survivors appended in source order.
    task automatic step_model(input string name, input logic [1:0] v, input int r0, input int r1);
        int rds[2];
        bit keep[2];
        int erdy, ecv, erd;
        bit any;
        rds[0] = r0;
        rds[1] = r1;
        any = 0;
        for (int i = 0; i < 2; i++) begin
            keep[i] = v[i] && (rds[i] != 0);
            any |= keep[i];
        end
        erdy = ((4 - mq.size()) >= 2) ? 1 : 0;
        ecv  = (mq.size() > 0) ? 1 : 0;
        erd  = (mq.size() > 0) ? mq[0] : 0;
`ifdef BP_BE_CLEAR_QUEUE_BYPASS_EN
        if (mq.size() == 0) begin
            for (int i = 0; i < 2; i++) begin
                if (keep[i] && ecv == 0) begin
                    ecv = 1;
                    erd = rds[i];
                    keep[i] = 0;
                end
            end
        end
`endif
        drive_chk(name, v, r0, r1, erdy, ecv, erd, mq.size(), movf);
        if (mq.size() > 0) void'(mq.pop_front());
        if (erdy == 1) begin
            for (int i = 0; i < 2; i++) if (keep[i]) mq.push_back(rds[i]);
        end else if (any) begin
            movf = 1;
        end
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        wb_v_i    = '0;
        wb_rd_i   = '0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;
        mq.delete();
        movf = 0;
    endtask

    initial begin
        // Fields: v, rd0, rd1, ready, clear_v, clear_rd, count, overflow (observed before the edge).
        tbl[0]  = '{2'b00,  0,  0, 1, 0,  0, 0, 0};
        tbl[1]  = '{2'b01,  5,  0, 1, 0,  0, 0, 0};
        tbl[2]  = '{2'b00,  0,  0, 1, 1,  5, 1, 0};
        tbl[3]  = '{2'b11,  3,  7, 1, 0,  0, 0, 0};
        tbl[4]  = '{2'b00,  0,  0, 1, 1,  3, 2, 0};
        tbl[5]  = '{2'b00,  0,  0, 1, 1,  7, 1, 0};
        tbl[6]  = '{2'b11,  0,  9, 1, 0,  0, 0, 0};
        tbl[7]  = '{2'b00,  0,  0, 1, 1,  9, 1, 0};
        tbl[8]  = '{2'b11,  1,  2, 1, 0,  0, 0, 0};
        tbl[9]  = '{2'b11,  3,  4, 1, 1,  1, 2, 0};
        tbl[10] = '{2'b00,  0,  0, 0, 1,  2, 3, 0};
        tbl[11] = '{2'b11, 10, 11, 1, 1,  3, 2, 0};
        tbl[12] = '{2'b01,  4,  0, 0, 1,  4, 3, 0};
        tbl[13] = '{2'b00,  0,  0, 1, 1, 10, 2, 1};
        tbl[14] = '{2'b00,  0,  0, 1, 1, 11, 1, 1};
        tbl[15] = '{2'b00,  0,  0, 1, 0,  0, 0, 1};

        reset_n_i = 1'b0;
        wb_v_i    = '0;
        wb_rd_i   = '0;
        #3;
        chk("por.clear_v",  int'(clear_v_o),  0);
        chk("por.count",    int'(count_o),    0);
        chk("por.ready",    int'(ready_o),    1);
        chk("por.overflow", int'(overflow_o), 0);
        do_reset();

`ifndef BP_BE_CLEAR_QUEUE_BYPASS_EN
        for (int k = 0; k < 16; k++) begin
            drive_chk($sformatf("vec%0d", k), tbl[k].v, tbl[k].r0, tbl[k].r1,
                      tbl[k].rdy, tbl[k].cv, tbl[k].rd, tbl[k].cnt, tbl[k].ovf);
        end
`else
        do_reset();
        drive_chk("byp0", 2'b11, 2, 6, 1, 1, 2, 0, 0);
        drive_chk("byp1", 2'b00, 0, 0, 1, 1, 6, 1, 0);
        drive_chk("byp2", 2'b00, 0, 0, 1, 0, 0, 0, 0);
`endif

        // Reset asserted mid-cycle while entries are queued.
        do_reset();
        step_model("load0", 2'b11, 3, 4);
        step_model("load1", 2'b11, 5, 6);
        @(posedge clk_i);
        #3;
        reset_n_i = 1'b0;
        #1;
        chk("midrst.clear_v",  int'(clear_v_o),  0);
        chk("midrst.count",    int'(count_o),    0);
        chk("midrst.ready",    int'(ready_o),    1);
        chk("midrst.overflow", int'(overflow_o), 0);
        do_reset();

        for (int k = 0; k < 600; k++) begin
            logic [1:0] v;
            v = ((k % 60) < 8) ? 2'b00 : 2'($urandom_range(0, 3));
            step_model($sformatf("rnd%0d", k), v, int'($urandom_range(0, 7)),
                       int'($urandom_range(0, 31)));
            if (k == 300) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
